adder_tree_feeder: RTL and testbench
====================================

ADDER_TREE_FEEDER -- requirements
Module: adder_tree_feeder

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 10, operand width in bits.
REQ-002 SHALL have parameter LEVELS, default 2, tree depth whose result is returned; legal values 2 or 3.
REQ-003 SHALL have parameter TREE_LATENCY, default 2, clock edges from op_valid rising to tree_sum being valid; legal range 1..15.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream operand valid.
REQ-007 SHALL have port in_ready  output  1  feeder accepts an operand this cycle.
REQ-008 SHALL have port in_data  input  ADDER_WIDTH  unsigned operand.
REQ-009 SHALL have port in_last  input  1  marks the final operand of a job; qualified by in_valid&in_ready.
REQ-010 SHALL have port op_bus  output  8*ADDER_WIDTH  lane k at bits [k*W+W-1:k*W], lane 0 = isum0_0_0_0 ... lane 7 = isum0_1_1_1.
REQ-011 SHALL have port op_valid  output  1  op_bus is stable and presented to the tree.
REQ-012 SHALL have port tree_sum  input  ADDER_WIDTH+3  sum returned by the tree; upper unused bits zero for LEVELS=2.
REQ-013 SHALL have port out_valid  output  1  result is valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port out_sum  output  ADDER_WIDTH+3  captured job result.

Function
REQ-016 SHALL implement states FILL, WAIT, HOLD; FILL after reset.
REQ-017 In FILL, in_ready SHALL be 1; in WAIT and HOLD in_ready SHALL be 0.
REQ-018 Each accepted beat (in_valid&in_ready) SHALL write in_data to lane index fill_cnt (3-bit counter, starts 0) and increment fill_cnt.
REQ-019 On acceptance of lane 7, or of any beat with in_last=1, next state SHALL be WAIT; lanes above the last written lane SHALL be driven 0.
REQ-020 Lanes SHALL be cleared to 0 on entry to FILL so zero-fill holds across jobs.
REQ-021 op_valid SHALL be 1 exactly in WAIT; op_bus SHALL not change while op_valid=1.
REQ-022 In WAIT a latency counter SHALL start at 0 on entry and increment each cycle; on the cycle it equals TREE_LATENCY-1... SHALL be read as: tree_sum SHALL be sampled into out_sum on the TREE_LATENCY-th rising edge after op_valid rose, and the state SHALL move to HOLD at that same edge.
REQ-023 In HOLD out_valid SHALL be 1 and out_sum SHALL be stable until out_valid&out_ready.
REQ-024 On out_valid&out_ready, next state SHALL be FILL with fill_cnt=0 and lanes cleared; no operand is accepted in that cycle.
REQ-025 in_last with fill_cnt=0 SHALL form a one-operand job (lanes 1..7 zero).
REQ-026 in_valid while in_ready=0 SHALL be ignored; no beat is dropped because upstream holds it.
REQ-027 out_sum SHALL be zero-extended, never truncated; no arithmetic is performed inside the feeder.

Reset
REQ-028 rst_n low SHALL asynchronously force state FILL, fill_cnt=0, all lanes 0, latency counter 0, out_sum 0, op_valid 0, out_valid 0; in_ready SHALL be 0 while rst_n is low and 1 from the first edge after release.
REQ-029 Reset asserted in any state SHALL abandon the job in progress; no partial result is emitted after release.

Verification (bench pairs the feeder with a TREE_LATENCY-cycle tree model)
REQ-030 LEVELS=3, operands 1..8 back-to-back, out_ready=1 -> op_valid after 8th beat, out_sum=36 after 2 edges, out_valid 1 cycle.
REQ-031 LEVELS=2, operands 1..8 -> out_sum=10 (lanes 0..3 only).
REQ-032 LEVELS=3, operands 5,6,7 with in_last on 7 -> lanes 3..7 = 0, out_sum=18; next job starts from lane 0.
REQ-033 LEVELS=3, eight operands 1023 -> out_sum=8184, no overflow in 13 bits.
REQ-034 out_ready held 0 for 5 cycles in HOLD -> out_valid, out_sum constant, in_ready=0 throughout, in_valid beats not consumed.
REQ-035 rst_n pulsed low during WAIT -> all outputs 0 immediately; after release a fresh job 2,2 (in_last) yields out_sum=4.

Source files
------------

// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: collects up to eight operands into lanes, presents them to an external adder tree and holds the returned sum
module adder_tree_feeder #(
  parameter int ADDER_WIDTH  = 10,
  parameter int LEVELS       = 2,
  parameter int TREE_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDER_WIDTH-1:0]   in_data,
  input  logic                     in_last,
  output logic [8*ADDER_WIDTH-1:0] op_bus,
  output logic                     op_valid,
  input  logic [ADDER_WIDTH+2:0]   tree_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDER_WIDTH+2:0]   out_sum
);
  localparam int W = ADDER_WIDTH;
  localparam logic [W+2:0] KEEP = {LEVELS == 2 ? 1'b0 : 1'b1, {(W+2){1'b1}}};
  typedef enum logic [1:0] {FILL, WAIT, HOLD} state_t;
  state_t state, state_nx;
  logic [2:0] fill_cnt;
  logic [3:0] lat;
  logic [W-1:0] lane [8];
  logic live, take, done, hit;
  // live keeps in_ready low until the first edge after reset release
  assign in_ready  = live && state == FILL;
  assign op_valid  = state == WAIT;
  assign out_valid = state == HOLD;
  assign take = in_valid && in_ready;
  assign done = out_valid && out_ready;
  assign hit  = lat == 4'(TREE_LATENCY - 1);
  genvar i;
  for (i = 0; i < 8; i++) begin : g_lane
    assign op_bus[i*W +: W] = lane[i];
  end
  always_comb begin
    state_nx = (state == FILL && take && (in_last || &fill_cnt)) ? WAIT :
               (state == WAIT && hit) ? HOLD :
               (state == HOLD && out_ready) ? FILL : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      live     <= 1'b0;
      fill_cnt <= '0;
      lat      <= '0;
      out_sum  <= '0;
      for (int k = 0; k < 8; k++) lane[k] <= '0;
    end else begin
      live  <= 1'b1;
      state <= state_nx;
      lat   <= op_valid ? lat + 4'd1 : 4'd0;
      if (take) begin
        lane[fill_cnt] <= in_data;
        fill_cnt       <= fill_cnt + 3'd1;
      end
      if (done) begin
        fill_cnt <= '0;
        for (int k = 0; k < 8; k++) lane[k] <= '0;
      end
      if (op_valid && hit) out_sum <= tree_sum & KEEP;
    end
  end
endmodule

// File: tb/tb_adder_tree_feeder.sv
// tb_adder_tree_feeder: directed checks of the feeder paired with one-register tree models at LEVELS 3 and 2
module tb_adder_tree_feeder;
  localparam int W = 10;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic [W-1:0] in_data = 0;
  logic in_ready3, op_valid3, out_valid3, in_ready2, op_valid2, out_valid2;
  logic [8*W-1:0] op_bus3, op_bus2, exp_bus;
  logic [W+2:0] tree3, tree2, out_sum3, out_sum2;
  logic [W-1:0] ops [8];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  adder_tree_feeder #(.ADDER_WIDTH(W), .LEVELS(3), .TREE_LATENCY(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .in_last(in_last), .op_bus(op_bus3), .op_valid(op_valid3), .tree_sum(tree3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_sum(out_sum3));
  adder_tree_feeder #(.ADDER_WIDTH(W), .LEVELS(2), .TREE_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .op_bus(op_bus2), .op_valid(op_valid2), .tree_sum(tree2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2));

  // two-cycle trees: one register stage, sampled by the feeder one edge later
  function automatic logic [W+2:0] tsum(input logic [8*W-1:0] b, input int n);
    logic [W+2:0] s = 0;
    for (int k = 0; k < n; k++) s += (W+3)'(b[k*W +: W]);
    return s;
  endfunction
  always @(posedge clk) begin
    tree3 <= tsum(op_bus3, 8);
    tree2 <= tsum(op_bus2, 4);
  end

  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1; in_data = ops[k]; in_last = (k == n - 1);
      checks++;
      if (in_ready3 !== 1'b1) begin failures++; $display("FAIL send_ready beat %0d got %b want 1", k, in_ready3); end
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic job(input string name, input int n, input int e3, input int e2);
    exp_bus = '0;
    for (int k = 0; k < n; k++) exp_bus[k*W +: W] = ops[k];
    out_ready = 1;
    send(n);
    checks++;
    if (op_valid3 !== 1'b1 || out_valid3 !== 1'b0) begin failures++; $display("FAIL %s_e0 op_valid=%b out_valid=%b want 1/0", name, op_valid3, out_valid3); end
    checks++;
    if (op_bus3 !== exp_bus) begin failures++; $display("FAIL %s_bus got %h want %h", name, op_bus3, exp_bus); end
    checks++;
    if (in_ready3 !== 1'b0) begin failures++; $display("FAIL %s_busy got %b want 0", name, in_ready3); end
    @(posedge clk); #1;
    checks++;
    if (op_valid3 !== 1'b1 || out_valid3 !== 1'b0 || op_bus3 !== exp_bus) begin failures++; $display("FAIL %s_e1 op_valid=%b out_valid=%b", name, op_valid3, out_valid3); end
    @(posedge clk); #1;
    checks++;
    if (op_valid3 !== 1'b0 || out_valid3 !== 1'b1) begin failures++; $display("FAIL %s_e2 op_valid=%b out_valid=%b want 0/1", name, op_valid3, out_valid3); end
    checks++;
    if (out_sum3 !== 13'(e3)) begin failures++; $display("FAIL %s_sum3 got %0d want %0d", name, out_sum3, e3); end
    checks++;
    if (out_sum2 !== 13'(e2) || out_valid2 !== 1'b1) begin failures++; $display("FAIL %s_sum2 got %0d want %0d", name, out_sum2, e2); end
    @(posedge clk); #1;
    checks++;
    if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1 || op_bus3 !== '0) begin failures++; $display("FAIL %s_e3 out_valid=%b in_ready=%b bus=%h want 0/1/0", name, out_valid3, in_ready3, op_bus3); end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready3, op_valid3, out_valid3} !== 3'b000 || op_bus3 !== '0 || out_sum3 !== '0) begin failures++; $display("FAIL reset_state rdy=%b opv=%b outv=%b sum=%0d", in_ready3, op_valid3, out_valid3, out_sum3); end
    @(posedge clk); #1;
    checks++;
    if (in_ready3 !== 1'b0) begin failures++; $display("FAIL reset_hold_ready got %b want 0", in_ready3); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0) begin failures++; $display("FAIL reset_release rdy=%b outv=%b want 1/0", in_ready3, out_valid3); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 8; k++) ops[k] = W'(k + 1);
    job("full", 8, 36, 10);
  endtask

  task automatic test_partial();
    ops[0] = 5; ops[1] = 6; ops[2] = 7;
    job("partial", 3, 18, 18);
    ops[0] = 4;
    job("single", 1, 4, 4);
  endtask

  task automatic test_max();
    for (int k = 0; k < 8; k++) ops[k] = 10'd1023;
    job("max", 8, 8184, 4092);
  endtask

  task automatic test_hold();
    ops[0] = 1; ops[1] = 2;
    out_ready = 0;
    send(2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_data = 99;
      checks++;
      if (out_valid3 !== 1'b1 || out_sum3 !== 13'd3 || in_ready3 !== 1'b0) begin failures++; $display("FAIL hold_c%0d outv=%b sum=%0d rdy=%b want 1/3/0", c, out_valid3, out_sum3, in_ready3); end
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1 || op_bus3 !== '0) begin failures++; $display("FAIL hold_release outv=%b rdy=%b bus=%h", out_valid3, in_ready3, op_bus3); end
    ops[0] = 3; ops[1] = 8; ops[2] = 1;
    job("after_hold", 3, 12, 12);
  endtask

  task automatic test_reset_wait();
    ops[0] = 9;
    send(1);
    checks++;
    if (op_valid3 !== 1'b1) begin failures++; $display("FAIL rw_wait got %b want 1", op_valid3); end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({in_ready3, op_valid3, out_valid3} !== 3'b000 || op_bus3 !== '0 || out_sum3 !== '0) begin failures++; $display("FAIL rw_async rdy=%b opv=%b outv=%b sum=%0d bus=%h", in_ready3, op_valid3, out_valid3, out_sum3, op_bus3); end
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid3 !== 1'b0 || op_valid3 !== 1'b0) begin failures++; $display("FAIL rw_idle_c%0d outv=%b opv=%b want 0/0", c, out_valid3, op_valid3); end
    end
    ops[0] = 2; ops[1] = 2;
    job("rw_fresh", 2, 4, 4);
  endtask

  initial begin
    test_reset();
    test_full();
    test_partial();
    test_max();
    test_hold();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
